// File: rtl/grid_renderer.sv
// Tile-grid video renderer: a 2-bit cell RAM drawn as coloured cells with gridlines.
// Cells are written through a valid/ready port; a clear sweep zeroes the RAM after reset or on request.
module grid_renderer #(
    parameter int unsigned GRID_W     = 40,
    parameter int unsigned GRID_H     = 30,
    parameter int unsigned CELL_LOG2  = 4,
    parameter logic [11:0] LINE_COLOR = 12'h444
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic        wr_valid_in,
    output logic        wr_ready_out,
    input  logic [5:0]  wr_col_in,
    input  logic [4:0]  wr_row_in,
    input  logic [1:0]  wr_data_in,
    input  logic        clear_in,
    output logic        busy_out,
    output logic [11:0] rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    localparam int unsigned NumCells = GRID_W * GRID_H;
    localparam int unsigned AddrW    = $clog2(NumCells);
    localparam logic [10:0] HMask    = 11'((1 << CELL_LOG2) - 1);
    localparam logic [9:0]  VMask    = 10'((1 << CELL_LOG2) - 1);
    localparam logic [AddrW-1:0] LastAddr = AddrW'(NumCells - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e           state_q, state_d;
    logic [AddrW-1:0] sweep_q, sweep_d;

    logic [1:0]       mem_q [NumCells];
    logic             mem_we;
    logic [AddrW-1:0] mem_waddr;
    logic [1:0]       mem_wdata;
    logic             wr_in_range;
    logic [AddrW-1:0] wr_addr;

    // Render pipeline state
    logic [10:0]      h1_q;
    logic [9:0]       v1_q;
    logic             hs1_q, vs1_q, bl1_q;
    logic             hs2_q, vs2_q, bl2_q, edge2_q, oob2_q;
    logic             hs3_q, vs3_q, bl3_q;
    logic [11:0]      rgb_q, rgb_d;
    logic [5:0]       col;
    logic [4:0]       row;
    logic             edge_d, oob_d;
    logic [AddrW-1:0] rd_addr;
    logic [1:0]       rd_data_q;

    // Out-of-range writes still handshake but never reach the RAM.
    always_comb begin
        wr_in_range = (32'(wr_col_in) < GRID_W) && (32'(wr_row_in) < GRID_H);
        wr_addr     = wr_in_range ?
                      AddrW'(wr_row_in) * AddrW'(GRID_W) + AddrW'(wr_col_in) : '0;
    end

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_addr;
        mem_wdata    = wr_data_in;
        busy_out     = 1'b0;
        wr_ready_out = 1'b0;
        unique case (state_q)
            StIdle: begin
                wr_ready_out = 1'b1;
                mem_we       = wr_valid_in && wr_in_range;
                if (clear_in) begin
                    state_d = StClear;
                    sweep_d = '0;
                end
            end
            StClear: begin
                busy_out  = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = 2'b00;
                if (sweep_q == LastAddr) begin
                    state_d = StIdle;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + AddrW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q <= StClear;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Read-first RAM: a same-address write lands after the read samples old data.
    always_ff @(posedge pixel_clk_in) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    always_comb begin
        col     = 6'(h1_q >> CELL_LOG2);
        row     = 5'(v1_q >> CELL_LOG2);
        oob_d   = (32'(col) >= GRID_W) || (32'(row) >= GRID_H);
        edge_d  = ((h1_q & HMask) == '0) || ((v1_q & VMask) == '0);
        rd_addr = oob_d ? '0 : AddrW'(row) * AddrW'(GRID_W) + AddrW'(col);
    end

    always_comb begin
        rgb_d = 12'h000;
        if (bl2_q || oob2_q) begin
            rgb_d = 12'h000;
        end else if (edge2_q) begin
            rgb_d = LINE_COLOR;
        end else begin
            unique case (rd_data_q)
                2'd0: rgb_d = 12'h000;
                2'd1: rgb_d = 12'hFFF;
                2'd2: rgb_d = 12'hF00;
                2'd3: rgb_d = 12'h0F0;
            endcase
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            h1_q    <= '0;
            v1_q    <= '0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            bl1_q   <= 1'b1;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
            bl2_q   <= 1'b1;
            edge2_q <= 1'b0;
            oob2_q  <= 1'b0;
            hs3_q   <= 1'b1;
            vs3_q   <= 1'b1;
            bl3_q   <= 1'b1;
            rgb_q   <= 12'h000;
        end else begin
            h1_q    <= hcount_in;
            v1_q    <= vcount_in;
            hs1_q   <= hsync_in;
            vs1_q   <= vsync_in;
            bl1_q   <= blank_in;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
            bl2_q   <= bl1_q;
            edge2_q <= edge_d;
            oob2_q  <= oob_d;
            hs3_q   <= hs2_q;
            vs3_q   <= vs2_q;
            bl3_q   <= bl2_q;
            rgb_q   <= rgb_d;
        end
    end

    assign rgb_out   = rgb_q;
    assign hsync_out = hs3_q;
    assign vsync_out = vs3_q;
    assign blank_out = bl3_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer: pixel scoreboard with 3-cycle latency,
// clear-sweep timing, write handshakes and reset behaviour.
module tb_grid_renderer;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in, vsync_in, blank_in;
    logic        wr_valid_in, wr_ready_out;
    logic [5:0]  wr_col_in;
    logic [4:0]  wr_row_in;
    logic [1:0]  wr_data_in;
    logic        clear_in, busy_out;
    logic [11:0] rgb_out;
    logic        hsync_out, vsync_out, blank_out;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
    } px_t;

    px_t        exp_q[$];
    logic [1:0] model [30][40];

    always #5 clk = ~clk;

    grid_renderer dut (
        .pixel_clk_in (clk),
        .rst_in       (rst_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .blank_in     (blank_in),
        .wr_valid_in  (wr_valid_in),
        .wr_ready_out (wr_ready_out),
        .wr_col_in    (wr_col_in),
        .wr_row_in    (wr_row_in),
        .wr_data_in   (wr_data_in),
        .clear_in     (clear_in),
        .busy_out     (busy_out),
        .rgb_out      (rgb_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .blank_out    (blank_out)
    );

    function automatic logic [11:0] model_rgb(input logic [10:0] h, input logic [9:0] v,
                                              input logic bl);
        int c, r;
        c = int'(h[9:4]);
        r = int'(v[8:4]);
        if (bl) return 12'h000;
        if (c >= 40 || r >= 30) return 12'h000;
        if (h[3:0] == 4'd0 || v[3:0] == 4'd0) return 12'h444;
        case (model[r][c])
            2'd0:    return 12'h000;
            2'd1:    return 12'hFFF;
            2'd2:    return 12'hF00;
            default: return 12'h0F0;
        endcase
    endfunction

    // One pixel per cycle; entry pushed now is compared three cycles later.
    task automatic drive_px(input string tag, input logic [10:0] h, input logic [9:0] v,
                            input logic hs, input logic vs, input logic bl);
        px_t e, got;
        hcount_in = h;
        vcount_in = v;
        hsync_in  = hs;
        vsync_in  = vs;
        blank_in  = bl;
        e.rgb = model_rgb(h, v, bl);
        e.hs  = hs;
        e.vs  = vs;
        e.bl  = bl;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 4) begin
            e   = exp_q.pop_front();
            got = {rgb_out, hsync_out, vsync_out, blank_out};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: got rgb=%h hs=%b vs=%b bl=%b, want rgb=%h hs=%b vs=%b bl=%b",
                         tag, got.rgb, got.hs, got.vs, got.bl, e.rgb, e.hs, e.vs, e.bl);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush_px(input string tag);
        repeat (3) drive_px(tag, 11'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic do_write(input string tag, input int c, input int r, input logic [1:0] d);
        int waitc = 0;
        wr_valid_in = 1'b1;
        wr_col_in   = 6'(c);
        wr_row_in   = 5'(r);
        wr_data_in  = d;
        @(negedge clk);
        while (!wr_ready_out && waitc < 3000) begin
            waitc++;
            @(negedge clk);
        end
        n_vec++;
        if (wr_ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL %s handshake: ready=%b, want 1", tag, wr_ready_out);
        end
        @(posedge clk);
        #1;
        wr_valid_in = 1'b0;
        if (c < 40 && r < 30) model[r][c] = d;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy_out && n < 5000) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n = 0;
        rst_in      = 1'b1;
        hcount_in   = '0;
        vcount_in   = '0;
        hsync_in    = 1'b0;
        vsync_in    = 1'b0;
        blank_in    = 1'b0;
        wr_valid_in = 1'b0;
        wr_col_in   = '0;
        wr_row_in   = '0;
        wr_data_in  = '0;
        clear_in    = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({rgb_out, hsync_out, vsync_out, blank_out} !== {12'h000, 3'b111}) begin
            n_err++;
            $display("FAIL reset_outputs: got rgb=%h hs=%b vs=%b bl=%b, want 000 1 1 1",
                     rgb_out, hsync_out, vsync_out, blank_out);
        end
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy_out !== 1'b1 || wr_ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_fsm: got busy=%b ready=%b, want busy=1 ready=0",
                     busy_out, wr_ready_out);
        end
        while (busy_out && n < 5000) begin
            if (n < 3) begin
                n_vec++;
                if ({rgb_out, hsync_out, vsync_out, blank_out} !== {12'h000, 3'b111}) begin
                    n_err++;
                    $display("FAIL pipe_reset_flush[%0d]: got rgb=%h hs=%b vs=%b bl=%b, want 000 1 1 1",
                             n, rgb_out, hsync_out, vsync_out, blank_out);
                end
            end
            n++;
            @(negedge clk);
        end
        n_vec++;
        if (n != 1200) begin
            n_err++;
            $display("FAIL reset_sweep_len: got %0d busy cycles, want 1200", n);
        end
        n_vec++;
        if (wr_ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_sweep: got %b, want 1", wr_ready_out);
        end
        @(posedge clk);
        #1;
        blank_in = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        foreach (model[r, c]) model[r][c] = 2'd0;
    endtask

    task automatic test_write_render;
        int vs_list[6] = '{47, 48, 49, 55, 63, 64};
        do_write("wr_5_3", 5, 3, 2'd2);
        exp_q.delete();
        foreach (vs_list[i]) begin
            for (int h = 76; h <= 98; h++) begin
                drive_px("render_cell", 11'(h), 10'(vs_list[i]), 1'(h % 5 == 0), 1'b1, 1'b0);
            end
        end
        flush_px("render_cell_flush");
    endtask

    task automatic test_sync_random;
        do_write("wr_1_1", 1, 1, 2'd1);
        do_write("wr_2_1", 2, 1, 2'd3);
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            drive_px("random_sync", 11'($urandom_range(0, 1023)), 10'($urandom_range(0, 511)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0));
        end
        for (int h = 0; h < 64; h++) begin
            drive_px("cells_row1", 11'(h), 10'd24, 1'b1, 1'b0, 1'b0);
        end
        flush_px("random_flush");
    endtask

    task automatic test_clear;
        int n = 0;
        int vs_list[3] = '{8, 24, 56};
        wr_valid_in = 1'b1;
        wr_col_in   = 6'd0;
        wr_row_in   = 5'd0;
        wr_data_in  = 2'd1;
        clear_in    = 1'b1;
        @(negedge clk);
        n_vec++;
        if (wr_ready_out !== 1'b1 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL clear_with_write: got ready=%b busy=%b, want ready=1 busy=0",
                     wr_ready_out, busy_out);
        end
        @(posedge clk);
        #1;
        wr_valid_in = 1'b0;
        clear_in    = 1'b0;
        @(negedge clk);
        while (busy_out && n < 5000) begin
            n++;
            clear_in = (n == 300);
            @(negedge clk);
        end
        clear_in = 1'b0;
        n_vec++;
        if (n != 1200) begin
            n_err++;
            $display("FAIL clear_sweep_len: got %0d busy cycles, want 1200", n);
        end
        @(posedge clk);
        #1;
        foreach (model[r, c]) model[r][c] = 2'd0;
        exp_q.delete();
        foreach (vs_list[i]) begin
            for (int h = 0; h < 100; h++) begin
                drive_px("after_clear", 11'(h), 10'(vs_list[i]), 1'b1, 1'b1, 1'b0);
            end
        end
        flush_px("after_clear_flush");
    endtask

    task automatic test_oob_write;
        do_write("wr_oob_45_2", 45, 2, 2'd3);
        exp_q.delete();
        for (int h = 0; h < 800; h += 2) begin
            drive_px("oob_row2", 11'(h), 10'd40, 1'b1, 1'b1, 1'b0);
        end
        for (int h = 0; h < 800; h += 2) begin
            drive_px("oob_row3", 11'(h), 10'd56, 1'b1, 1'b1, 1'b0);
        end
        flush_px("oob_flush");
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        clear_in = 1'b1;
        @(posedge clk);
        #1;
        clear_in = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        rst_in   = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        blank_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({rgb_out, hsync_out, vsync_out, blank_out} !== {12'h000, 3'b111}) begin
            n_err++;
            $display("FAIL mid_sweep_reset_outputs: got rgb=%h hs=%b vs=%b bl=%b, want 000 1 1 1",
                     rgb_out, hsync_out, vsync_out, blank_out);
        end
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        count_busy(n);
        n_vec++;
        if (n != 1200) begin
            n_err++;
            $display("FAIL restart_sweep_len: got %0d busy cycles, want 1200", n);
        end
        n_vec++;
        if (wr_ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_restart: got %b, want 1", wr_ready_out);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_render();
        test_sync_random();
        test_clear();
        test_oob_write();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
